// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Bit-counter width for an M-bit multiplier: clog2(M-1), at least one bit.
   function automatic int unsigned cnt_width(input int unsigned m);
      return (m > 2) ? $clog2(m - 1) : 1;
   endfunction

   // Packs the low (n-1) accumulator bits into an n-bit signed result.
   // A zero magnitude negates to zero, so -0 never appears.
   function automatic logic [63:0] pack_result(input logic [63:0] low, input logic sign,
                                               input logic ovf, input logic sat,
                                               input int unsigned n);
      logic [63:0] mask;
      logic [63:0] mag;
      mask = (64'd1 << (n - 1)) - 64'd1;
      mag  = low & mask;
      if (sat && ovf) mag = mask;
      return sign ? (64'd0 - mag) : mag;
   endfunction

endpackage

// File: rtl/abs_sign.sv
// Splits a two's-complement value into its sign bit and (W-1)-bit magnitude.
module abs_sign #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] x,
   output logic         sgn,
   output logic [W-2:0] mag
);

   localparam int unsigned MagW = W - 1;

   // The most negative value wraps to a zero magnitude.
   always_comb begin
      sgn = x[W-1];
      mag = x[W-1] ? MagW'(~x + 1'b1) : x[W-2:0];
   end

endmodule

// File: rtl/seq_mul_signed.sv
// Sequential shift-add signed multiplier, one multiplier bit per cycle.
// Define SEQ_MUL_SAT_EN to saturate the product on magnitude overflow.
module seq_mul_signed
   import seq_mul_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned M = N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [M-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] O,
   output logic         ovf
);

   localparam int unsigned AccW = N + M - 2;
   localparam int unsigned CntW = cnt_width(M);
`ifdef SEQ_MUL_SAT_EN
   localparam logic SatEn = 1'b1;
`else
   localparam logic SatEn = 1'b0;
`endif

   state_t          state_q;
   logic            sign_q;
   logic [AccW-1:0] a_sh_q;
   logic [M-2:0]    b_sh_q;
   logic [AccW-1:0] acc_q;
   logic [CntW-1:0] cnt_q;

   logic            a_sgn, b_sgn;
   logic [N-2:0]    a_mag;
   logic [M-2:0]    b_mag;
   logic [AccW-1:0] acc_nxt;
   logic            ovf_nxt;

   abs_sign #(.W(N)) u_abs_a (.x(A), .sgn(a_sgn), .mag(a_mag));
   abs_sign #(.W(M)) u_abs_b (.x(B), .sgn(b_sgn), .mag(b_mag));

   // Multiplicand shifts left and multiplier shifts right, so bit 0 gates each add.
   always_comb begin
      acc_nxt = acc_q + (b_sh_q[0] ? a_sh_q : '0);
      ovf_nxt = |acc_nxt[AccW-1:N-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         O         <= '0;
         ovf       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q   <= a_sgn ^ b_sgn;
                  a_sh_q   <= AccW'(a_mag);
                  b_sh_q   <= b_mag;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q  <= acc_nxt;
               a_sh_q <= a_sh_q << 1;
               b_sh_q <= b_sh_q >> 1;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CntW'(M - 2)) begin
                  O         <= N'(pack_result(64'(acc_nxt[N-2:0]), sign_q, ovf_nxt, SatEn, N));
                  ovf       <= ovf_nxt;
                  out_valid <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_signed.sv
// Directed-vector bench for seq_mul_signed at N=M=8 (honours SEQ_MUL_SAT_EN).
module tb_seq_mul_signed;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] O;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   seq_mul_signed #(.N(8), .M(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .out_valid(out_valid), .out_ready(out_ready), .O(O), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Present operands, wait for out_valid; reports latency in edges after acceptance.
   task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b,
                                 output int lat, output logic timed_out);
      A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      timed_out = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || O !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b O=%h ovf=%b, want 1 0 00 0",
                  in_ready, out_valid, O, ovf);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat; logic to;
      start_and_wait(8'd3, 8'hFC, lat, to);
      checks++;
      if (to || lat != 7) begin
         errors++;
         $display("FAIL basic_latency: got %0d (timeout %b), want 7", lat, to);
      end
      checks++;
      if (O !== 8'hF4 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_3x-4: O=%h ovf=%b, want f4 0", O, ovf);
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_overflow();
      int lat; logic to;
      logic [7:0] exp_pos, exp_neg;
`ifdef SEQ_MUL_SAT_EN
      exp_pos = 8'h7F; exp_neg = 8'h81;
`else
      exp_pos = 8'h48; exp_neg = 8'hB8;
`endif
      start_and_wait(8'd100, 8'd2, lat, to);
      checks++;
      if (to || O !== exp_pos || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_100x2: O=%h ovf=%b to=%b, want %h 1", O, ovf, to, exp_pos);
      end
      release_result();
      start_and_wait(8'h9C, 8'd2, lat, to);
      checks++;
      if (to || O !== exp_neg || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_-100x2: O=%h ovf=%b to=%b, want %h 1", O, ovf, to, exp_neg);
      end
      release_result();
   endtask

   task automatic test_most_negative();
      int lat; logic to;
      start_and_wait(8'h80, 8'd5, lat, to);
      checks++;
      if (to || O !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL most_neg_0x80x5: O=%h ovf=%b to=%b, want 00 0", O, ovf, to);
      end
      release_result();
   endtask

   task automatic test_hold();
      int lat; logic to;
      start_and_wait(8'd5, 8'd6, lat, to);
      checks++;
      if (to || O !== 8'h1E) begin
         errors++;
         $display("FAIL hold_initial: O=%h to=%b, want 1e", O, to);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid; A = 8'(i * 37 + 1); B = 8'(i * 11 + 3);
         @(posedge clk); #1;
         checks++;
         if (O !== 8'h1E || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: O=%h out_valid=%b in_ready=%b, want 1e 1 0",
                     i, O, out_valid, in_ready);
         end
      end
      in_valid = 1'b1;
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_no_accept_on_release: in_ready=%b out_valid=%b, want 1 0",
                  in_ready, out_valid);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_result: out_valid=%b at cycle %0d, want 0", out_valid, i);
         end
      end
   endtask

   task automatic test_reset_mid_calc();
      A = 8'd9; B = 8'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || O !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b O=%h ovf=%b, want 1 0 00 0",
                  in_ready, out_valid, O, ovf);
      end
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: out_valid=%b in_ready=%b at %0d, want 0 1",
                     out_valid, in_ready, i);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic to;
      start_and_wait(8'hF9, 8'hF7, lat, to);
      checks++;
      if (to || lat != 7 || O !== 8'h3F || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_-7x-9: O=%h ovf=%b lat=%0d to=%b, want 3f 0 7", O, ovf, lat, to);
      end
      release_result();
      start_and_wait(8'h00, 8'hFF, lat, to);
      checks++;
      if (to || lat != 7 || O !== 8'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_0x-1: O=%h ovf=%b lat=%0d to=%b, want 00 0 7", O, ovf, lat, to);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_most_negative();
      test_hold();
      test_reset_mid_calc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
